// File: rtl/usart_rx_fifo_if.sv
// CPU-side read port of the USART receiver: FIFO head, pop/clear strobes, status.
// master = CPU (drives RdEn/ClrErr), slave = receiver (drives everything else).
interface usart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              RdEn;
    logic              ClrErr;
    logic [DATA_W-1:0] RdData;
    logic [1:0]        RdFlags;
    logic [LVL_W-1:0]  Level;
    logic [4:0]        Status;
    logic              Overrun;
    logic              Timeout;

    modport master (
        output RdEn, ClrErr,
        input  RdData, RdFlags, Level, Status, Overrun, Timeout
    );

    modport slave (
        input  RdEn, ClrErr,
        output RdData, RdFlags, Level, Status, Overrun, Timeout
    );
endinterface

// File: rtl/usart_rx_fifo.sv
// Oversampled asynchronous USART receiver (5-9 data bits, none/even/odd parity,
// 1/2 stop bits) feeding a show-ahead receive FIFO with per-word {FE,PE} tags.
// Optional feature: define USART_RX_TIMEOUT_EN to enable the idle timeout
// counter; otherwise Timeout is tied low.
module usart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int OVS    = 16
) (
    input  logic        CPUClk,
    input  logic        Reset_n,
    input  logic        Enable,
    input  logic [15:0] BaudDiv,
    input  logic [1:0]  ParMode,
    input  logic        StopBits,
    input  logic        SLBit,
    usart_rx_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W  = $clog2(OVS);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int WORD_W = DATA_W + 2;

    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(OVS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t             state;
    logic               sync1, sync2, line;
    logic [15:0]        div_cnt;
    logic               tick;
    logic               line_prev;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               fe, pe;
    logic               push_req, cp;
    logic               par_en, start_det;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               fe_st, pe_st, overrun;
    logic               full, empty, pop, accept;

    assign line      = sync2;
    assign tick      = Enable && (div_cnt == '0);
    assign par_en    = (ParMode == 2'b01) || (ParMode == 2'b10);
    assign start_det = tick && (state == S_IDLE) && line_prev && !line;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge CPUClk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= SLBit;
            sync2 <= sync1;
        end
    end

    // Baud tick generator: reloads from BaudDiv, ticks on zero, parked while disabled.
    always_ff @(posedge CPUClk or negedge Reset_n) begin
        if (!Reset_n)
            div_cnt <= '0;
        else if (!Enable || div_cnt == '0)
            div_cnt <= BaudDiv;
        else
            div_cnt <= div_cnt - 16'd1;
    end

    // Frame FSM: start validation, data shift, parity/stop checks, push request.
    always_ff @(posedge CPUClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            line_prev <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            fe        <= 1'b0;
            pe        <= 1'b0;
            push_req  <= 1'b0;
            cp        <= 1'b0;
        end else begin
            push_req <= 1'b0;
            cp       <= 1'b0;
            if (!Enable) begin
                state <= S_IDLE;
            end else if (tick) begin
                // Previous tick's line level: a start edge needs a high sample first.
                line_prev <= line;
                case (state)
                    S_IDLE: begin
                        if (line_prev && !line) begin
                            state <= S_START;
                            cnt   <= CNT_W'(1);
                            fe    <= 1'b0;
                            pe    <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (cnt == HALF_TICK) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= line ? S_IDLE : S_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == FULL_TICK) begin
                            cnt   <= '0;
                            shreg <= {line, shreg[DATA_W-1:1]};
                            if (bit_idx == LAST_BIT)
                                state <= par_en ? S_PARITY : S_STOP1;
                            else
                                bit_idx <= bit_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (cnt == FULL_TICK) begin
                            cnt   <= '0;
                            pe    <= line != ((ParMode == 2'b10) ? ~^shreg : ^shreg);
                            state <= S_STOP1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP1, S_STOP2: begin
                        if (cnt == FULL_TICK) begin
                            cnt <= '0;
                            if (!line)
                                fe <= 1'b1;
                            if (state == S_STOP1 && StopBits) begin
                                state <= S_STOP2;
                            end else begin
                                state    <= S_IDLE;
                                push_req <= 1'b1;
                                cp       <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign full   = (level == LVL_W'(DEPTH));
    assign empty  = (level == '0);
    assign pop    = bus.RdEn && !empty;
    assign accept = push_req && (!full || pop);

    // FIFO storage, pointers, level and sticky error flags.
    always_ff @(posedge CPUClk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: storage is reset too, because a reset must wipe any received words.
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            fe_st   <= 1'b0;
            pe_st   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {fe, pe, shreg};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                level <= level + 1'b1;
            else if (pop && !accept)
                level <= level - 1'b1;
            // A new error in the same cycle as ClrErr keeps the flag set.
            fe_st   <= (fe_st && !bus.ClrErr) || (push_req && fe);
            pe_st   <= (pe_st && !bus.ClrErr) || (push_req && pe);
            overrun <= (overrun && !bus.ClrErr) || (push_req && !accept);
        end
    end

    assign bus.RdData  = empty ? '0 : mem[rd_ptr][DATA_W-1:0];
    assign bus.RdFlags = empty ? '0 : mem[rd_ptr][WORD_W-1:DATA_W];
    assign bus.Level   = level;
    assign bus.Status  = {cp, full, empty, fe_st, pe_st};
    assign bus.Overrun = overrun;

`ifdef USART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = OVS * 40;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout;

    // Idle timeout: counts ticks while idle with data waiting; pop/start/empty clear it.
    always_ff @(posedge CPUClk or negedge Reset_n) begin
        if (!Reset_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (start_det || pop || empty) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (tick && state == S_IDLE && !timeout) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_W'(TO_LIMIT - 1))
                timeout <= 1'b1;
        end
    end

    assign bus.Timeout = timeout;
`else
    assign bus.Timeout = 1'b0;
`endif
endmodule

// File: tb/tb_usart_rx_fifo.sv
// Self-checking bench for usart_rx_fifo: a queue-based model of the receive FIFO
// and sticky flags, updated once per transmitted frame / pop / clear, compared
// against the DUT every idle cycle, plus hand-computed literal expectations.
module tb_usart_rx_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int OVS    = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        enable    = 1'b0;
    logic [15:0] baud_div  = 16'd0;
    logic [1:0]  par_mode  = 2'b00;
    logic        stop_bits = 1'b0;
    logic        sl_bit    = 1'b1;

    usart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    usart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVS(OVS)) dut (
        .CPUClk  (clk),
        .Reset_n (rst_n),
        .Enable  (enable),
        .BaudDiv (baud_div),
        .ParMode (par_mode),
        .StopBits(stop_bits),
        .SLBit   (sl_bit),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model state: queue of {FE,PE,data} words plus sticky flags.
    logic [DATA_W+1:0] q[$];
    bit m_fe, m_pe, m_ov;
    bit busy = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int cp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] pack(input logic [7:0] d, input logic [1:0] f,
                                         input logic [4:0] lvl, input logic [4:0] st,
                                         input logic ov, input logic to);
        return {d, f, lvl, st, ov, to};
    endfunction

    function automatic logic [21:0] dut_vec();
        return pack(bus.RdData, bus.RdFlags, bus.Level, bus.Status, bus.Overrun, bus.Timeout);
    endfunction

    // Count CP pulses (one-cycle high) sampled mid-cycle.
    always @(negedge clk)
        if (bus.Status[4] === 1'b1)
            cp_count++;

    // Compare process: whenever no frame is in flight, DUT must equal the model.
    logic [7:0] e_data;
    logic [1:0] e_flags;
    always @(negedge clk) begin
        if (rst_n && !busy) begin
            e_data  = (q.size() != 0) ? q[0][DATA_W-1:0] : 8'h00;
            e_flags = (q.size() != 0) ? q[0][DATA_W+1:DATA_W] : 2'b00;
            check("model", {10'd0, dut_vec()},
                  {10'd0, pack(e_data, e_flags, 5'(q.size()),
                               {1'b0, q.size() == DEPTH, q.size() == 0, m_fe, m_pe},
                               m_ov, 1'b0)});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        sl_bit = b;
        idle(OVS * (int'(baud_div) + 1));
    endtask

    // Transmit one frame; bad_par flips the parity bit, bad_stop2 sends a low 2nd stop.
    task automatic send_frame(input logic [DATA_W-1:0] d, input bit bad_par, input bit bad_stop2);
        int  cp0;
        bit  par_on, exp_fe, exp_pe;
        logic good_par;
        busy     = 1'b1;
        cp0      = cp_count;
        par_on   = (par_mode == 2'b01) || (par_mode == 2'b10);
        good_par = (par_mode == 2'b10) ? ~^d : ^d;
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++)
            drive_bit(d[i]);
        if (par_on)
            drive_bit(good_par ^ bad_par);
        drive_bit(1'b1);
        if (stop_bits)
            drive_bit(!bad_stop2);
        sl_bit = 1'b1;
        idle(3);
        check("cp_pulses", cp_count - cp0, 1);
        exp_fe = stop_bits && bad_stop2;
        exp_pe = par_on && bad_par;
        if (q.size() < DEPTH)
            q.push_back({exp_fe, exp_pe, d});
        else
            m_ov = 1'b1;
        m_fe |= exp_fe;
        m_pe |= exp_pe;
        busy = 1'b0;
    endtask

    task automatic pop_word();
        bus.RdEn = 1'b1;
        @(posedge clk);
        #1;
        if (q.size() != 0)
            void'(q.pop_front());
        bus.RdEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr_err();
        bus.ClrErr = 1'b1;
        @(posedge clk);
        #1;
        m_fe = 1'b0;
        m_pe = 1'b0;
        m_ov = 1'b0;
        bus.ClrErr = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_format(input logic [1:0] pm, input logic sb);
        enable = 1'b0;
        idle(2);
        par_mode  = pm;
        stop_bits = sb;
        idle(2);
        enable = 1'b1;
        idle(2);
    endtask

    initial begin
        int cp0;
        bus.RdEn   = 1'b0;
        bus.ClrErr = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #1 check("reset_vals", {10'd0, dut_vec()}, {10'd0, pack(8'h00, 2'b00, 5'd0, 5'b00100, 1'b0, 1'b0)});
        idle(3);
        rst_n = 1'b1;
        idle(2);
        busy = 1'b0;
        set_format(2'b00, 1'b0);

        // 8N1, 0xA5
        send_frame(8'hA5, 1'b0, 1'b0);
        check("a5_data", bus.RdData, 8'hA5);
        check("a5_flags", bus.RdFlags, 2'b00);
        check("a5_level", bus.Level, 5'd1);
        check("a5_status", bus.Status, 5'b00000);
        pop_word();
        check("a5_popped_av", bus.Status[2], 1'b1);

        // Even parity, 0x03 sent with parity bit 1 -> PE
        set_format(2'b01, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        check("pe_flags", bus.RdFlags, 2'b01);
        check("pe_sticky", bus.Status[0], 1'b1);
        pop_word();
        check("pe_sticky_after_pop", bus.Status[0], 1'b1);
        clr_err();
        check("pe_cleared", bus.Status[0], 1'b0);

        // Odd parity, correct parity bit -> clean word
        set_format(2'b10, 1'b0);
        send_frame(8'h5E, 1'b0, 1'b0);
        check("odd_ok_flags", bus.RdFlags, 2'b00);
        pop_word();

        // Two stop bits, second low -> FE
        set_format(2'b00, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("fe_data", bus.RdData, 8'h3C);
        check("fe_flags", bus.RdFlags, 2'b10);
        check("fe_sticky", bus.Status[1], 1'b1);

        // Enable dropped mid-frame: frame discarded, FIFO untouched
        busy = 1'b1;
        cp0 = cp_count;
        sl_bit = 1'b0;
        idle(OVS * 3);
        enable = 1'b0;
        idle(2);
        sl_bit = 1'b1;
        idle(2);
        enable = 1'b1;
        idle(OVS * 2);
        check("disable_no_cp", cp_count - cp0, 0);
        busy = 1'b0;
        idle(2);

        // Short low glitch (4 ticks) -> false start
        busy = 1'b1;
        cp0 = cp_count;
        sl_bit = 1'b0;
        idle(4);
        sl_bit = 1'b1;
        idle(OVS * 2);
        check("glitch_no_cp", cp_count - cp0, 0);
        check("glitch_level", bus.Level, 5'd1);
        busy = 1'b0;
        idle(2);

        // Reset during DATA: everything back to reset values
        busy = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(OVS / 2);
        rst_n = 1'b0;
        #1 check("midframe_reset", {10'd0, dut_vec()}, {10'd0, pack(8'h00, 2'b00, 5'd0, 5'b00100, 1'b0, 1'b0)});
        q.delete();
        m_fe = 1'b0;
        m_pe = 1'b0;
        m_ov = 1'b0;
        sl_bit = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        busy = 1'b0;

        // Overflow: DEPTH+1 frames, no reads
        set_format(2'b00, 1'b0);
        for (int i = 0; i <= DEPTH; i++)
            send_frame(8'(i), 1'b0, 1'b0);
        check("ovf_ov", bus.Status[3], 1'b1);
        check("ovf_overrun", bus.Overrun, 1'b1);
        check("ovf_level", bus.Level, 5'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_pop_order", bus.RdData, 32'(i));
            pop_word();
        end
        check("ovf_drained_av", bus.Status[2], 1'b1);
        check("ovf_drained_data", bus.RdData, 8'h00);
        clr_err();
        check("overrun_cleared", bus.Overrun, 1'b0);

`ifdef USART_RX_TIMEOUT_EN
        // Idle timeout with one stored word
        send_frame(8'h77, 1'b0, 1'b0);
        busy = 1'b1;
        idle(OVS * 40 + 10);
        check("timeout_set", bus.Timeout, 1'b1);
        pop_word();
        check("timeout_cleared", bus.Timeout, 1'b0);
        busy = 1'b0;
`else
        check("timeout_tied", bus.Timeout, 1'b0);
`endif
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
